bcd_scan_ctrl: RTL and testbench
================================

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 SHALL have parameter N, default 10: binary input width; legal range 4..16.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per displayed digit; legal range 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Num_b, input, N bits: unsigned binary value to display.
REQ-006 SHALL have port load, input, 1 bit: request to convert and latch Num_b.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when new digits are latched.
REQ-009 SHALL have port overflow, output, 1 bit: the last latched value exceeded 9999.
REQ-010 SHALL have port seg_out, output, [0:6]: shared segments a..g, active-low, same per-digit encoding as decoder_7_seg.
REQ-011 SHALL have port an_out, output, 4 bits: one-hot, active-low digit enable; bit 0 = units, bit 3 = thousands.

Function
REQ-012 SHALL implement the FSM states IDLE, CONV and SHOW.
REQ-013 SHALL sample Num_b and move to CONV when load=1 at an edge in IDLE or SHOW, including the edge where done=1.
REQ-014 SHALL ignore load in CONV, with no queuing.
REQ-015 SHALL hold busy=1 in CONV and busy=0 otherwise.
REQ-016 SHALL run CONV as an iterative shift-add-3 (double-dabble) over exactly N cycles, using a 5-digit internal BCD register.
REQ-017 SHALL, at the edge of the N-th shift, load the four display digit registers atomically, move to SHOW and assert done for exactly the following cycle.
REQ-018 SHALL set the load-to-done latency to N+1 edges: load sampled at edge k, done high in the cycle after edge k+N.
REQ-019 SHALL keep showing the previously latched digits throughout CONV.
REQ-020 SHALL, at latch time with a value above 9999 (possible only for N of 14 or more), latch digits 9,9,9,9 and set overflow=1.
REQ-021 SHALL, at latch time with a value of 9999 or less, clear overflow.
REQ-022 SHALL run the scan prescaler 0..SCAN_DIV-1 continuously from reset, independent of the FSM.
REQ-023 SHALL advance the digit index 0,1,2,3,0 cyclically on each prescaler wrap.
REQ-024 SHALL drive an_out low on the bit for the current index and drive seg_out with the encoding of the current index's digit register.
REQ-025 SHALL register seg_out and an_out together so that both change on the same edge.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force the FSM to IDLE and clear the prescaler, digit index and digit registers to 0.
REQ-027 SHALL, while rst=1, force busy=0, done=0, overflow=0, an_out=4'b1110 and seg_out=7'b0000001 (digit 0).
REQ-028 SHALL, on reset asserted mid-CONV, abort the conversion with no done pulse; digits read 0 after reset.
REQ-029 SHALL ignore load while rst=1.

Configuration
REQ-030 SHALL, when macro LEADING_ZERO_BLANK_EN is defined, drive seg_out=7'b1111111 for the thousands, hundreds and tens digits when they and all higher digits are zero; units SHALL always be shown and an_out scanning SHALL be unchanged.
REQ-031 SHALL, when LEADING_ZERO_BLANK_EN is undefined, display all four digits including leading zeros.

Verification (bench uses N=10, SCAN_DIV=4)
REQ-032 SHALL cover: Num_b=1023, load pulse at edge k -> busy high for cycles k..k+9, done in the cycle after edge k+10, digits 1,0,2,3, overflow=0.
REQ-033 SHALL cover: after loading 1023, observe 16 cycles -> an_out steps 1110, 1101, 1011, 0111 every 4 cycles, with seg_out showing 3, 2, 0, 1 respectively.
REQ-034 SHALL cover: load 5 with LEADING_ZERO_BLANK_EN defined -> thousands, hundreds and tens show 1111111 and units shows 5; with the macro undefined -> 0,0,0,5 shown.
REQ-035 SHALL cover: load 512, then load 7 at cycle 3 of CONV -> the second load is ignored and done latches 5,1,2.
REQ-036 SHALL cover: rst asserted at cycle 5 of CONV -> no done pulse, busy=0, an_out=1110 and seg_out=0000001 immediately.
REQ-037 SHALL cover, with N=14: load 12345 -> digits 9,9,9,9 and overflow=1; then load 42 -> overflow=0 and digits 0,0,4,2.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// Binary-to-BCD converter (iterative double-dabble) driving a 4-digit multiplexed 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on the upper three digits.
module bcd_scan_ctrl #(
  parameter int N        = 10,
  parameter int SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] Num_b,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [0:6]   seg_out,
  output logic [3:0]   an_out
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(N + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    bin_sh;
  logic [19:0]     bcd_sh;
  logic [19:0]     bcd_adj;
  logic [19:0]     bcd_nxt;
  logic [CW-1:0]   bit_cnt;
  logic [3:0][3:0] dig;
  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic            last_shift;
  logic            start;
  logic [0:6]      seg_nxt;
  logic [3:0]      an_nxt;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [0:6] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign busy       = (state == CONV);
  assign start      = (state != CONV) && load;
  assign last_shift = (state == CONV) && (bit_cnt == LAST_BIT);

  // Conversion step: add-3 correction on every BCD digit, then shift in the next binary MSB
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++) bcd_adj[i*4 +: 4] = add3(bcd_sh[i*4 +: 4]);
    bcd_nxt = {bcd_adj[18:0], bin_sh[N-1]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, SHOW: if (load) state_nxt = CONV;
      CONV:       if (last_shift) state_nxt = SHOW;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Conversion datapath and atomic digit latch; bit 19 can never be set for N <= 16
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_sh   <= '0;
      bcd_sh   <= '0;
      bit_cnt  <= '0;
      dig      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last_shift;
      if (start) begin
        bin_sh  <= Num_b;
        bcd_sh  <= '0;
        bit_cnt <= '0;
      end else if (state == CONV) begin
        bin_sh  <= {bin_sh[N-2:0], 1'b0};
        bcd_sh  <= bcd_nxt;
        bit_cnt <= bit_cnt + 1'b1;
        if (last_shift) begin
          if (bcd_nxt[19:16] != 4'd0) begin
            dig      <= {4'd9, 4'd9, 4'd9, 4'd9};
            overflow <= 1'b1;
          end else begin
            dig      <= bcd_nxt[15:0];
            overflow <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    an_nxt  = ~(4'b0001 << idx);
    seg_nxt = seg_enc(dig[idx]);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx == 2'd3 && dig[3] == 4'd0) ||
        (idx == 2'd2 && dig[3] == 4'd0 && dig[2] == 4'd0) ||
        (idx == 2'd1 && dig[3] == 4'd0 && dig[2] == 4'd0 && dig[1] == 4'd0))
      seg_nxt = 7'b1111111;
`endif
  end

  // Output stage: segments and anode registered together so they switch on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= 7'b0000001;
      an_out  <= 4'b1110;
    end else begin
      seg_out <= seg_nxt;
      an_out  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl: N=10 and N=14 instances, SCAN_DIV=4.
module tb_bcd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  num_a = '0;
  logic        load_a = 1'b0;
  logic        busy_a, done_a, ovf_a;
  logic [0:6]  seg_a;
  logic [3:0]  an_a;
  logic [13:0] num_b = '0;
  logic        load_b = 1'b0;
  logic        busy_b, done_b, ovf_b;
  logic [0:6]  seg_b;
  logic [3:0]  an_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0000100;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z  = 7'b1111111;
`else
  localparam logic [6:0] Z  = S0;
`endif

  bcd_scan_ctrl #(.N(10), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .Num_b(num_a), .load(load_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a), .seg_out(seg_a), .an_out(an_a));

  bcd_scan_ctrl #(.N(14), .SCAN_DIV(4)) dut14 (
    .clk(clk), .rst(rst), .Num_b(num_b), .load(load_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b), .seg_out(seg_b), .an_out(an_b));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_digit(input bit wide, input int pos, input logic [6:0] exp, input string tag);
    logic [3:0] want;
    bit hit;
    want = ~(4'b0001 << pos);
    hit  = 1'b0;
    tick;
    for (int i = 0; i < 40; i++) begin
      if ((wide ? an_b : an_a) === want) begin
        hit = 1'b1;
        break;
      end
      tick;
    end
    chk(32'(hit), 32'd1, {tag, "_found"});
    chk(32'(wide ? seg_b : seg_a), 32'(exp), tag);
  endtask

  task automatic load_wait(input bit wide, input int val, input int lat, input string tag);
    int n;
    if (wide) begin num_b = val[13:0]; load_b = 1'b1; end
    else      begin num_a = val[9:0];  load_a = 1'b1; end
    tick;
    load_a = 1'b0;
    load_b = 1'b0;
    n = 1;
    while (!(wide ? done_b : done_a) && n < 60) begin
      tick;
      n++;
    end
    chk(32'(n), 32'(lat), {tag, "_latency"});
    tick;
    chk(32'(wide ? done_b : done_a), 32'd0, {tag, "_pulse_end"});
  endtask

  initial begin
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    logic [3:0] prev;
    bit hit;
    bit saw_done;
    int n;

    #1 rst = 1'b1;
    tick; tick; tick;
    chk(32'(busy_a), 0, "rst_busy");
    chk(32'(done_a), 0, "rst_done");
    chk(32'(ovf_a), 0, "rst_ovf");
    chk(32'(an_a), 32'hE, "rst_an");
    chk(32'(seg_a), 32'(S0), "rst_seg");
    rst = 1'b0;
    tick;

    // 1023: busy for N cycles, done after edge k+N
    num_a = 10'd1023;
    load_a = 1'b1;
    tick;
    load_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk(32'(busy_a), 1, "conv_busy");
      chk(32'(done_a), 0, "conv_no_done");
      tick;
    end
    chk(32'(done_a), 1, "done_1023");
    chk(32'(busy_a), 0, "busy_after_1023");
    chk(32'(ovf_a), 0, "ovf_1023");

    // Scan sequence: units, tens, hundreds, thousands, 4 cycles each
    exp_an[0] = 4'b1110; exp_seg[0] = S3;
    exp_an[1] = 4'b1101; exp_seg[1] = S2;
    exp_an[2] = 4'b1011; exp_seg[2] = S0;
    exp_an[3] = 4'b0111; exp_seg[3] = S1;
    prev = an_a;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (an_a == 4'b1110 && prev != 4'b1110) begin
        hit = 1'b1;
        break;
      end
      prev = an_a;
    end
    chk(32'(hit), 1, "scan_align");
    for (int i = 0; i < 16; i++) begin
      chk(32'(an_a), 32'(exp_an[i/4]), "scan_an");
      chk(32'(seg_a), 32'(exp_seg[i/4]), "scan_seg");
      tick;
    end

    load_wait(1'b0, 5, 11, "five");
    check_digit(1'b0, 0, S5, "five_d0");
    check_digit(1'b0, 1, Z, "five_d1");
    check_digit(1'b0, 2, Z, "five_d2");
    check_digit(1'b0, 3, Z, "five_d3");

    // 512 with a second load attempted mid-conversion
    num_a = 10'd512;
    load_a = 1'b1;
    tick;
    load_a = 1'b0;
    tick; tick;
    num_a = 10'd7;
    load_a = 1'b1;
    tick;
    load_a = 1'b0;
    chk(32'(busy_a), 1, "ign_busy");
    n = 4;
    while (!done_a && n < 60) begin
      tick;
      n++;
    end
    chk(32'(n), 11, "ign_latency");
    check_digit(1'b0, 0, S2, "ign_d0");
    check_digit(1'b0, 1, S1, "ign_d1");
    check_digit(1'b0, 2, S5, "ign_d2");
    check_digit(1'b0, 3, Z, "ign_d3");

    // Reset during conversion
    num_a = 10'd300;
    load_a = 1'b1;
    tick;
    load_a = 1'b0;
    tick; tick; tick; tick;
    rst = 1'b1;
    #1;
    chk(32'(busy_a), 0, "abort_busy");
    chk(32'(done_a), 0, "abort_done");
    chk(32'(an_a), 32'hE, "abort_an");
    chk(32'(seg_a), 32'(S0), "abort_seg");
    tick; tick;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done_a) saw_done = 1'b1;
    end
    chk(32'(saw_done), 0, "abort_no_done");
    check_digit(1'b0, 0, S0, "abort_d0");
    check_digit(1'b0, 1, Z, "abort_d1");

    // N=14: overflow then recovery
    load_wait(1'b1, 12345, 15, "ovf");
    chk(32'(ovf_b), 1, "ovf_set");
    check_digit(1'b1, 0, S9, "ovf_d0");
    check_digit(1'b1, 1, S9, "ovf_d1");
    check_digit(1'b1, 2, S9, "ovf_d2");
    check_digit(1'b1, 3, S9, "ovf_d3");
    load_wait(1'b1, 42, 15, "small");
    chk(32'(ovf_b), 0, "ovf_clear");
    check_digit(1'b1, 0, S2, "small_d0");
    check_digit(1'b1, 1, S4, "small_d1");
    check_digit(1'b1, 2, Z, "small_d2");
    check_digit(1'b1, 3, Z, "small_d3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
